// File: rtl/pipelined_cla_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// Stage 1 registers bit and group propagate/generate; stage 2 resolves carries and flags.
module pipelined_cla_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] input_1,
    input  logic [WIDTH-1:0] input_2,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf,
    output logic             zero
);
    localparam int NG = WIDTH / GROUP;

    // Handshake: a beat moves on a rising edge when the sender's valid and the
    // receiver's ready are both high; valid never depends on ready.
    logic adv1, adv2;
    logic s1_valid;

    assign adv2     = !out_valid || out_ready;
    assign adv1     = !s1_valid || adv2;
    assign in_ready = adv1;

    logic [WIDTH-1:0] b_eff, p_next, g_next;
    logic [NG-1:0]    pg_next, gg_next;
    logic             c0_next;

    always_comb begin
        b_eff   = sub ? ~input_2 : input_2;
        p_next  = input_1 ^ b_eff;
        g_next  = input_1 & b_eff;
        c0_next = sub ? 1'b1 : cin;
        pg_next = '0;
        gg_next = '0;
        for (int k = 0; k < NG; k++) begin
            pg_next[k] = &p_next[k*GROUP +: GROUP];
            gg_next[k] = g_next[k*GROUP+3]
                       | (p_next[k*GROUP+3] & g_next[k*GROUP+2])
                       | (p_next[k*GROUP+3] & p_next[k*GROUP+2] & g_next[k*GROUP+1])
                       | (p_next[k*GROUP+3] & p_next[k*GROUP+2] & p_next[k*GROUP+1]
                          & g_next[k*GROUP]);
        end
    end

    logic [WIDTH-1:0] s1_p, s1_g;
    logic [NG-1:0]    s1_pg, s1_gg;
    logic             s1_c0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_p     <= '0;
            s1_g     <= '0;
            s1_pg    <= '0;
            s1_gg    <= '0;
            s1_c0    <= 1'b0;
        end else if (adv1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_p  <= p_next;
                s1_g  <= g_next;
                s1_pg <= pg_next;
                s1_gg <= gg_next;
                s1_c0 <= c0_next;
            end
        end
    end

    // Group carries are flattened sum-of-products terms, not a ripple chain.
    logic [NG:0] gc;

    always_comb begin : lookahead
        logic term;
        logic acc;
        gc = '0;
        for (int k = 0; k <= NG; k++) begin
            acc = s1_c0;
            for (int j = 0; j < k; j++) acc = acc & s1_pg[j];
            for (int j = 0; j < k; j++) begin
                term = s1_gg[j];
                for (int m = j + 1; m < k; m++) term = term & s1_pg[m];
                acc = acc | term;
            end
            gc[k] = acc;
        end
    end

    logic [WIDTH-1:0] bit_c, sum_next;

    always_comb begin : group_carries
        logic c;
        bit_c = '0;
        for (int k = 0; k < NG; k++) begin
            c = gc[k];
            for (int i = 0; i < GROUP; i++) begin
                bit_c[k*GROUP+i] = c;
                c = s1_g[k*GROUP+i] | (s1_p[k*GROUP+i] & c);
            end
        end
        sum_next = s1_p ^ bit_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            co        <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else if (adv2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                sum  <= sum_next;
                co   <= gc[NG];
                ovf  <= bit_c[WIDTH-1] ^ gc[NG];
                zero <= (sum_next == '0);
            end
        end
    end

endmodule

// File: doc/pipelined_cla_adder.md
PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 Parameter WIDTH SHALL default to 16: operand/sum width, a multiple of 4, range 4..64.
REQ-002 Parameter GROUP SHALL be fixed at 4: bits per carry-lookahead group, giving NG = WIDTH/4 groups.
REQ-003 clk  input  1: the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1: reset, asynchronous and active-low.
REQ-005 in_valid  input  1: the operand beat is valid.
REQ-006 in_ready  output  1: the block accepts the beat this cycle.
REQ-007 input_1  input  WIDTH: operand A.
REQ-008 input_2  input  WIDTH: operand B.
REQ-009 cin  input  1: carry-in; ignored when sub=1.
REQ-010 sub  input  1: 0 = A+B+cin, 1 = A-B (A + ~B + 1).
REQ-011 out_valid  output  1: the result beat is valid.
REQ-012 out_ready  input  1: the consumer accepts the result.
REQ-013 sum  output  WIDTH: result.
REQ-014 co  output  1: carry out of the MSB; for sub, 1 means no borrow.
REQ-015 ovf  output  1: two's-complement signed overflow.
REQ-016 zero  output  1: sum equals 0.

Function
REQ-017 Stage 1 SHALL register, per group, the bit p=a^b', the bit g=a&b', group propagate PG=AND of the 4 p bits, group generate GG=g3|p3g2|p3p2g1|p3p2p1g0, and the effective carry-in (b' = ~B when sub=1, carry-in = 1 when sub=1).
REQ-018 Stage 2 SHALL compute each group's carry-in by lookahead over the registered PG/GG, form the sum bits from p XOR the internal carries, and register sum/co/ovf/zero.
REQ-019 Latency SHALL be exactly 2 cycles from accept (in_valid&in_ready) to out_valid with no stall, and throughput SHALL be 1 beat/cycle.
REQ-020 ovf SHALL equal the carry into the MSB XOR the carry out of the MSB.
REQ-021 Stage 2 SHALL advance when !out_valid | out_ready; stage 1 SHALL advance when !s1_valid | the stage-2 advance condition; in_ready SHALL equal the stage-1 advance condition (combinational from out_ready; no other combinational input-to-output paths).
REQ-022 When out_valid=1 and out_ready=0, sum/co/ovf/zero SHALL hold stable and out_valid SHALL stay 1.
REQ-023 A stage not advancing SHALL hold its data and valid; no beat SHALL be dropped, duplicated or reordered.
REQ-024 With out_ready held low, at most 2 beats SHALL be in flight; in_ready SHALL deassert once both stages are full.
REQ-025 Simultaneous accept at the input and drain at the output with both stages full SHALL shift the pipeline without a bubble.
REQ-026 Arithmetic SHALL wrap modulo 2^WIDTH; 0xFFFF+1 (WIDTH=16) gives sum 0, co 1.

Reset
REQ-027 On rst_n low, out_valid and s1_valid SHALL clear immediately (asynchronously), and sum/co/ovf/zero SHALL reset to 0.
REQ-028 in_ready SHALL read 1 during reset and in the first cycle after reset release.
REQ-029 Beats in flight when reset asserts SHALL be discarded; no stale result SHALL appear after release.

Verification (WIDTH=16)
REQ-030 Add 0xFFFF + 0x0001, cin=0 -> 2 cycles later: sum=0x0000, co=1, ovf=0, zero=1.
REQ-031 Add 0x7FFF + 0x0001 -> sum=0x8000, co=0, ovf=1, zero=0; add 0x1234+0x1111, cin=1 -> sum=0x2346, co=0.
REQ-032 Sub 0x8000 - 0x0001 -> sum=0x7FFF, co=1, ovf=1; sub 0x0003 - 0x0005 -> sum=0xFFFE, co=0, ovf=0.
REQ-033 out_ready=0 for 6 cycles with in_valid held high and 3 beats offered -> only 2 accepted, in_ready=0, outputs stable; on out_ready=1 results emerge in order and the 3rd beat is accepted.
REQ-034 rst_n pulsed low with 2 beats in flight -> out_valid=0 immediately; after release no result appears until a new beat arrives plus 2 cycles.
REQ-035 Run 10k random beats with random sub/cin and random in_valid/out_ready against a behavioural A±B model -> every result matches on all flags; WIDTH=4 and WIDTH=64 also pass.
